// File: rtl/health_round_ctrl.sv
// Purpose : round sequencer and health owner for two players; round-robin damage arbiter feeding the status bar.
// Latency : an accepted hit updates curr_health_l/r on the next edge; readies are combinational from valid.
// Backpres: at most one hit is accepted per cycle, and only in FIGHT; the losing requester holds valid/dmg until it sees ready.
//
// Ports:
//   clk, rst_n                      clock and async active-low reset
//   start_round                     pulse that starts a round, or restarts one from FIGHT
//   hit_l_valid/dmg/ready           damage request against the left player
//   hit_r_valid/dmg/ready           damage request against the right player
//   final_health_l/r                animated health values shown by the status bar
//   curr_health_l/r                 registered health values sent to the status bar
//   round_active, ko, winner        round status flags
//   state_o                         IDLE=0 REFILL=1 FIGHT=2 DRAIN=3 KO_HOLD=4
module health_round_ctrl #(
    parameter logic [8:0]  MAX_HEALTH     = 9'd400,
    parameter logic [31:0] DRAIN_TIMEOUT  = 32'd50_000_000,
    parameter logic [31:0] KO_HOLD_CYCLES = 32'd200_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_round,
    input  logic       hit_l_valid,
    input  logic [7:0] hit_l_dmg,
    output logic       hit_l_ready,
    input  logic       hit_r_valid,
    input  logic [7:0] hit_r_dmg,
    output logic       hit_r_ready,
    input  logic [8:0] final_health_l,
    input  logic [8:0] final_health_r,
    output logic [8:0] curr_health_l,
    output logic [8:0] curr_health_r,
    output logic       round_active,
    output logic       ko,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REFILL = 3'd1;
    localparam logic [2:0] ST_FIGHT  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_KO     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [8:0]  hl_q, hl_d, hr_q, hr_d;
    logic        ko_q, ko_d;
    logic [1:0]  win_q, win_d;
    logic        prio_q, prio_d;     // 0: left wins a tie, 1: right wins a tie
    logic        loser_q, loser_d;   // 0: left lost, 1: right lost
    logic        grant_l, grant_r, accept_ok, enter_refill;
    logic [8:0]  new_l, new_r, loser_final;

    // A start_round in FIGHT takes precedence, so no hit is taken in that cycle.
    assign accept_ok   = (state_q == ST_FIGHT) && !start_round;
    assign grant_l     = hit_l_valid && (!hit_r_valid || !prio_q);
    assign grant_r     = hit_r_valid && (!hit_l_valid ||  prio_q);
    assign hit_l_ready = accept_ok && grant_l;
    assign hit_r_ready = accept_ok && grant_r;

    // Saturating subtract: damage larger than the remaining health leaves 0.
    assign new_l = (hl_q > {1'b0, hit_l_dmg}) ? (hl_q - {1'b0, hit_l_dmg}) : 9'd0;
    assign new_r = (hr_q > {1'b0, hit_r_dmg}) ? (hr_q - {1'b0, hit_r_dmg}) : 9'd0;

    assign loser_final = loser_q ? final_health_r : final_health_l;

    always_comb begin
        state_d      = state_q;
        hl_d         = hl_q;
        hr_d         = hr_q;
        ko_d         = ko_q;
        win_d        = win_q;
        prio_d       = prio_q;
        loser_d      = loser_q;
        enter_refill = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_round) enter_refill = 1'b1;
            end
            ST_REFILL: begin
                // Leave once the bar shows both players full, or give up waiting.
                if (((final_health_l == MAX_HEALTH) && (final_health_r == MAX_HEALTH)) ||
                    (cnt_q == DRAIN_TIMEOUT - 32'd1)) begin
                    state_d = ST_FIGHT;
                end
            end
            ST_FIGHT: begin
                if (start_round) begin
                    enter_refill = 1'b1;
                end else if (hit_l_ready) begin
                    hl_d   = new_l;
                    prio_d = 1'b1;
                    if (new_l == 9'd0) begin
                        state_d = ST_DRAIN;
                        loser_d = 1'b0;
                    end
                end else if (hit_r_ready) begin
                    hr_d   = new_r;
                    prio_d = 1'b0;
                    if (new_r == 9'd0) begin
                        state_d = ST_DRAIN;
                        loser_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Hold KO back until the loser's bar has finished dropping.
                if ((loser_final == 9'd0) || (cnt_q == DRAIN_TIMEOUT - 32'd1)) begin
                    state_d = ST_KO;
                    ko_d    = 1'b1;
                    win_d   = loser_q ? 2'b01 : 2'b10;
                end
            end
            ST_KO: begin
                if (cnt_q == KO_HOLD_CYCLES - 32'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_refill) begin
            state_d = ST_REFILL;
            hl_d    = MAX_HEALTH;
            hr_d    = MAX_HEALTH;
            ko_d    = 1'b0;
            win_d   = 2'b00;
            prio_d  = 1'b0;
        end
    end

    // The counter restarts on every state change, including FIGHT->REFILL.
    assign cnt_d = (state_d != state_q) ? 32'd0 : (cnt_q + 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
            hl_q    <= MAX_HEALTH;
            hr_q    <= MAX_HEALTH;
            ko_q    <= 1'b0;
            win_q   <= 2'b00;
            prio_q  <= 1'b0;
            loser_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
            ko_q    <= ko_d;
            win_q   <= win_d;
            prio_q  <= prio_d;
            loser_q <= loser_d;
        end
    end

    assign curr_health_l = hl_q;
    assign curr_health_r = hr_q;
    assign round_active  = (state_q == ST_FIGHT);
    assign ko            = ko_q;
    assign winner        = win_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_health_round_ctrl.sv
module tb_health_round_ctrl;

    localparam int MAXH = 20;
    localparam int DT   = 8;
    localparam int KOC  = 4;

    logic       clk;
    logic       rst_n;
    logic       start_round;
    logic       hit_l_valid, hit_r_valid;
    logic [7:0] hit_l_dmg, hit_r_dmg;
    logic       hit_l_ready, hit_r_ready;
    logic [8:0] final_health_l, final_health_r;
    logic [8:0] curr_health_l, curr_health_r;
    logic       round_active, ko;
    logic [1:0] winner;
    logic [2:0] state_o;

    health_round_ctrl #(
        .MAX_HEALTH    (9'd20),
        .DRAIN_TIMEOUT (32'd8),
        .KO_HOLD_CYCLES(32'd4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_round   (start_round),
        .hit_l_valid   (hit_l_valid),
        .hit_l_dmg     (hit_l_dmg),
        .hit_l_ready   (hit_l_ready),
        .hit_r_valid   (hit_r_valid),
        .hit_r_dmg     (hit_r_dmg),
        .hit_r_ready   (hit_r_ready),
        .final_health_l(final_health_l),
        .final_health_r(final_health_r),
        .curr_health_l (curr_health_l),
        .curr_health_r (curr_health_r),
        .round_active  (round_active),
        .ko            (ko),
        .winner        (winner),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model: phase number, health values, tie-break owner, loser,
    // and how many edges have passed since the phase was entered.
    int m_ph, m_hl, m_hr, m_win, m_age;
    bit m_ko, m_prio_left, m_loser_left, m_lacc, m_racc;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_hl = MAXH; m_hr = MAXH; m_win = 0; m_age = 0;
        m_ko = 0; m_prio_left = 1; m_loser_left = 0; m_lacc = 0; m_racc = 0;
    endtask

    task automatic model_ready(input bit st, input bit lv, input bit rv, output bit el, output bit er);
        el = 0; er = 0;
        if (m_ph == 2 && !st) begin
            if (lv && rv) begin
                el = m_prio_left;
                er = !m_prio_left;
            end else begin
                el = lv;
                er = rv;
            end
        end
    endtask

    function automatic int sat_sub(input int h, input int d);
        return (h > d) ? h - d : 0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int  nxt;
        bit  el, er;
        int  lf;
        nxt = m_ph;
        model_ready(start_round, hit_l_valid, hit_r_valid, el, er);
        m_lacc = el && hit_l_valid;
        m_racc = er && hit_r_valid;
        if ((m_ph == 0 || m_ph == 2) && start_round) begin
            nxt = 1; m_hl = MAXH; m_hr = MAXH; m_ko = 0; m_win = 0; m_prio_left = 1;
        end else if (m_ph == 1) begin
            if ((final_health_l == MAXH && final_health_r == MAXH) || m_age == DT - 1) nxt = 2;
        end else if (m_ph == 2) begin
            if (m_lacc) begin
                m_hl = sat_sub(m_hl, hit_l_dmg);
                m_prio_left = 0;
                if (m_hl == 0) begin nxt = 3; m_loser_left = 1; end
            end else if (m_racc) begin
                m_hr = sat_sub(m_hr, hit_r_dmg);
                m_prio_left = 1;
                if (m_hr == 0) begin nxt = 3; m_loser_left = 0; end
            end
        end else if (m_ph == 3) begin
            lf = m_loser_left ? int'(final_health_l) : int'(final_health_r);
            if (lf == 0 || m_age == DT - 1) begin
                nxt = 4; m_ko = 1; m_win = m_loser_left ? 2 : 1;
            end
        end else if (m_ph == 4) begin
            if (m_age == KOC - 1) nxt = 0;
        end
        if (nxt != m_ph) m_age = 0;
        else m_age++;
        m_ph = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit el, er;
        if (chk_en) begin
            model_ready(start_round, hit_l_valid, hit_r_valid, el, er);
            chk("hit_l_ready", int'(hit_l_ready), int'(el));
            chk("hit_r_ready", int'(hit_r_ready), int'(er));
            chk("state_o", int'(state_o), m_ph);
            chk("curr_health_l", int'(curr_health_l), m_hl);
            chk("curr_health_r", int'(curr_health_r), m_hr);
            chk("round_active", int'(round_active), int'(m_ph == 2));
            chk("ko", int'(ko), int'(m_ko));
            chk("winner", int'(winner), m_win);
        end
    end

    initial begin
        int mode;
        rst_n = 1; start_round = 0;
        hit_l_valid = 0; hit_r_valid = 0; hit_l_dmg = 0; hit_r_dmg = 0;
        final_health_l = 9'd20; final_health_r = 9'd20;
        #2 rst_n = 0;
        model_reset();
        chk_en = 1;
        tick(); tick();
        rst_n = 1;
        chk("rst_health_l", int'(curr_health_l), 20);
        chk("rst_health_r", int'(curr_health_r), 20);
        chk("rst_ko", int'(ko), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_ready", int'(hit_l_ready | hit_r_ready), 0);

        // Start a round with the bar already full.
        start_round = 1;
        tick();
        start_round = 0;
        chk("dir_refill", int'(state_o), 1);
        tick();
        chk("dir_fight", int'(state_o), 2);
        chk("dir_active", int'(round_active), 1);

        // Simultaneous hits: left first, right next.
        hit_l_valid = 1; hit_l_dmg = 3; hit_r_valid = 1; hit_r_dmg = 5;
        #1 chk("dir_tie_l", int'(hit_l_ready), 1);
        chk("dir_tie_r", int'(hit_r_ready), 0);
        tick();
        hit_l_valid = 0;
        #1 chk("dir_r_next", int'(hit_r_ready), 1);
        tick();
        hit_r_valid = 0;
        chk("dir_hl17", int'(curr_health_l), 17);
        chk("dir_hr15", int'(curr_health_r), 15);

        // The next tie again goes left; zero damage changes nothing.
        hit_l_valid = 1; hit_l_dmg = 0; hit_r_valid = 1; hit_r_dmg = 0;
        #1 chk("dir_tie2_l", int'(hit_l_ready), 1);
        tick(); hit_l_valid = 0;
        tick(); hit_r_valid = 0;
        chk("dir_dmg0", int'(curr_health_l) * 100 + int'(curr_health_r), 1715);
        hit_l_valid = 1;
        tick(); hit_l_valid = 0;

        // Abort from FIGHT with hits offered: nothing is accepted, healths refill.
        start_round = 1; hit_l_valid = 1; hit_l_dmg = 3; hit_r_valid = 1; hit_r_dmg = 5;
        #1 chk("dir_abort_rdy", int'(hit_l_ready | hit_r_ready), 0);
        tick();
        start_round = 0;
        chk("dir_abort_state", int'(state_o), 1);
        chk("dir_abort_hl", int'(curr_health_l), 20);
        tick();
        #1 chk("dir_prio_reset", int'(hit_l_ready), 1);
        tick(); hit_l_valid = 0;
        tick(); hit_r_valid = 0;
        chk("dir_17_15", int'(curr_health_l) * 100 + int'(curr_health_r), 1715);

        // Knock out right; KO waits for the right bar to reach 0.
        hit_r_valid = 1; hit_r_dmg = 8'd200;
        tick(); hit_r_valid = 0;
        chk("dir_drain", int'(state_o), 3);
        chk("dir_hr0", int'(curr_health_r), 0);
        hit_l_valid = 1; hit_l_dmg = 1;
        #1 chk("dir_drain_rdy", int'(hit_l_ready), 0);
        hit_l_valid = 0;
        tick();
        chk("dir_drain_wait", int'(state_o), 3);
        final_health_r = 0;
        tick();
        chk("dir_ko", int'(ko), 1);
        chk("dir_winner", int'(winner), 1);
        chk("dir_ko_state", int'(state_o), 4);
        repeat (3) tick();
        chk("dir_ko_hold", int'(state_o), 4);
        tick();
        chk("dir_idle", int'(state_o), 0);
        chk("dir_idle_ko", int'(ko), 1);

        // DRAIN timeout with the loser's bar stuck at 9.
        final_health_r = 20; start_round = 1;
        tick(); start_round = 0;
        tick();
        hit_r_valid = 1; hit_r_dmg = 8'd200;
        tick(); hit_r_valid = 0; final_health_r = 9;
        repeat (7) tick();
        chk("dir_to_drain", int'(state_o), 3);
        tick();
        chk("dir_to_ko", int'(state_o), 4);
        repeat (4) tick();
        chk("dir_to_idle", int'(state_o), 0);

        // REFILL timeout while the left bar never reaches full.
        final_health_l = 5; final_health_r = 20; start_round = 1;
        tick(); start_round = 0;
        repeat (7) tick();
        chk("dir_refill_wait", int'(state_o), 1);
        tick();
        chk("dir_refill_to", int'(state_o), 2);
        hit_l_valid = 1; hit_l_dmg = 3;
        tick(); hit_l_valid = 0;
        chk("dir_pre_rst", int'(curr_health_l), 17);

        // Asynchronous reset mid-round.
        rst_n = 0; model_reset();
        #1 chk("dir_arst_state", int'(state_o), 0);
        chk("dir_arst_hl", int'(curr_health_l), 20);
        chk("dir_arst_active", int'(round_active), 0);
        tick(); tick();
        rst_n = 1;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (hit_l_valid && m_lacc) hit_l_valid = 0;
            if (hit_r_valid && m_racc) hit_r_valid = 0;
            if (!hit_l_valid && ($urandom % 3 == 0)) begin
                hit_l_valid = 1;
                case ($urandom % 4)
                    0: hit_l_dmg = 0;
                    1: hit_l_dmg = 8'($urandom_range(1, 5));
                    2: hit_l_dmg = 8'($urandom_range(1, 20));
                    default: hit_l_dmg = 8'($urandom % 256);
                endcase
            end
            if (!hit_r_valid && ($urandom % 3 == 0)) begin
                hit_r_valid = 1;
                case ($urandom % 4)
                    0: hit_r_dmg = 0;
                    1: hit_r_dmg = 8'($urandom_range(1, 5));
                    2: hit_r_dmg = 8'($urandom_range(1, 20));
                    default: hit_r_dmg = 8'($urandom % 256);
                endcase
            end
            start_round = ($urandom % 40 == 0);
            mode = $urandom % 4;
            if (mode == 0) begin
                final_health_l = 9'(m_hl); final_health_r = 9'(m_hr);
            end else if (mode == 1) begin
                final_health_l = 9'(MAXH); final_health_r = 9'(MAXH);
            end else if (mode == 2) begin
                final_health_l = 9'($urandom_range(0, MAXH));
                final_health_r = 9'($urandom_range(0, MAXH));
            end
            if ($urandom % 1500 == 0) begin
                rst_n = 0; model_reset();
                hit_l_valid = 0; hit_r_valid = 0; start_round = 0;
                tick();
                rst_n = 1;
            end
            tick();
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
